sound_arbiter: RTL and testbench
================================

# sound_arbiter

Priority arbiter and sequencer that shares the single piezo tone generator between the alarm melody, a keypad click, and the lullaby. It replaces the plain OR-merge of two piezo outputs with one `playSound` code driving one piezo instance. It enforces priority and preemption, inserts a silent gap at every source handover, and times the click tone on the divided tick.

## Interface
Parameters:
- `BEAT_W`, 13: width of a tone code; code 0 means silence.
- `CLICK_TONE`, 13'd523: tone code played for a key click.
- `CLICK_TICKS`, 5: click duration in ticks, ≥1.
- `GAP_TICKS`, 1: silent gap at handover in ticks, ≥1.

Ports:
- `clock`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `tick`, in, 1: one-cycle strobe from the clock divider.
- `req_alarm`, in, 1: level request from the alarm sequencer.
- `beat_alarm`, in, BEAT_W: alarm tone code.
- `req_lullaby`, in, 1: level request from the lullaby sequencer.
- `beat_lullaby`, in, BEAT_W: lullaby tone code.
- `key_press`, in, 1: one-cycle pulse per debounced key.
- `playSound`, out, BEAT_W: tone code to the piezo.
- `grant`, out, 3: one-hot {alarm, click, lullaby}, or 0 when no source is granted.
- `busy`, out, 1: asserted whenever state ≠ IDLE.

## Operation
- States: IDLE, LULLABY, CLICK, ALARM, GAP.
- Priority: alarm > click > lullaby.
- `click_pend` flag:
  - Set by `key_press` when state ≠ ALARM and `req_alarm` = 0.
  - Cleared on entry to CLICK.
  - `key_press` during ALARM, or while `req_alarm` = 1, is discarded.
- IDLE: the first true condition wins: `req_alarm` → ALARM; `click_pend` → CLICK; `req_lullaby` → LULLABY. There is no gap from IDLE.
- LULLABY:
  - `req_alarm` or `click_pend` → GAP.
  - `req_lullaby` = 0 → IDLE.
- ALARM: `req_alarm` = 0 → IDLE. A click never preempts ALARM.
- CLICK:
  - Tick counter cleared on entry; incremented on each `tick`.
  - Counter reaches CLICK_TICKS → GAP.
  - `req_alarm` → GAP immediately; the click is aborted, not resumed.
  - `key_press` in CLICK restarts the counter (extends the click); `click_pend` is not set.
- GAP:
  - Counter cleared on entry; leave on the `tick` at which it reaches GAP_TICKS.
  - On exit, apply the IDLE decision in that same cycle. No source requested → IDLE.
- Outputs per state:
  - IDLE/GAP: `playSound` = 0, `grant` = 000.
  - LULLABY: `beat_lullaby`, 001.
  - CLICK: CLICK_TONE, 010.
  - ALARM: `beat_alarm`, 100.
- Reset (asynchronous, any state): state IDLE; `playSound` 0; `grant` 0; `busy` 0; `click_pend` 0; counter 0. A reset in mid-click or mid-gap leaves no residue.

## Timing
- State, `grant`, `busy` and `playSound` are all registers updated on the same `clock` edge. `playSound` is computed from the next state and the current beats.
- Latency is 1 cycle: request to grant, and beat change to `playSound` change while granted.
- Requests are sampled every cycle; `tick` only paces the CLICK and GAP counters.
- `key_press` and `req_alarm` rising in the same cycle: `req_alarm` wins and the key is discarded.
- Lullaby preempted by a click:
  - GAP, then CLICK for CLICK_TICKS ticks, then GAP.
  - LULLABY resumes if still requested. The lullaby sequencer keeps running; notes played during the click are lost.
- Counter width: $clog2(max(CLICK_TICKS, GAP_TICKS)+1). The counter saturates and never wraps.

## Structure
- Shared package `nap_pkg` holds:
  - the state enum;
  - grant bit indices (GNT_LULLABY=0, GNT_CLICK=1, GNT_ALARM=2);
  - `BEAT_W`.
- Sub-module `tick_timer`: clear, count on `tick`, and a `done` compare against a runtime limit. It is reused for the CLICK and GAP durations.
- The FSM and the output register stay in `sound_arbiter`.

## Test plan
- Reset, then `req_lullaby`=1 with `beat_lullaby`=100: `grant`=001 one cycle later, and `playSound` tracks beat changes with 1-cycle latency.
- LULLABY active, `key_press` pulse: `playSound`=0 for 1 tick, then 523 for 5 ticks, then 0 for 1 tick, then the lullaby resumes with `grant`=001.
- CLICK in progress, `req_alarm`=1 at tick 2: GAP for 1 tick, then ALARM with `grant`=100. A later `key_press` during ALARM gives no click after `req_alarm` drops; the state goes to IDLE.
- `key_press` and `req_alarm` in the same cycle from IDLE: ALARM is entered directly (no gap) and `click_pend` stays 0.
- Asynchronous reset asserted mid-GAP and mid-CLICK: all outputs 0 immediately. After release with no requests the block stays IDLE; `busy`=0.

Source files
------------

// File: rtl/nap_pkg.sv
// rtl/nap_pkg.sv - shared types and constants for the piezo sound arbiter
package nap_pkg;

  localparam int BEAT_W = 13;

  localparam int GNT_LULLABY = 0;
  localparam int GNT_CLICK   = 1;
  localparam int GNT_ALARM   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LULLABY,
    ST_CLICK,
    ST_ALARM,
    ST_GAP
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sound_arbiter_if.sv
// rtl/sound_arbiter_if.sv - request/beat inputs and piezo outputs of the sound arbiter
interface sound_arbiter_if;
  import nap_pkg::*;

  logic              tick;
  logic              req_alarm;
  logic [BEAT_W-1:0] beat_alarm;
  logic              req_lullaby;
  logic [BEAT_W-1:0] beat_lullaby;
  logic              key_press;
  logic [BEAT_W-1:0] playSound;
  logic [2:0]        grant;
  logic              busy;

  modport master (
    output tick, req_alarm, beat_alarm, req_lullaby, beat_lullaby, key_press,
    input  playSound, grant, busy
  );

  modport slave (
    input  tick, req_alarm, beat_alarm, req_lullaby, beat_lullaby, key_press,
    output playSound, grant, busy
  );

endinterface

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - saturating tick counter with a runtime limit compare
module tick_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // done fires on the tick that brings the count up to the limit, so the owner leaves on that tick
  assign done_o = tick_i && (({1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, limit_i});

endmodule

// File: rtl/sound_arbiter.sv
// rtl/sound_arbiter.sv - shares one piezo between alarm, key click and lullaby
// with priority, preemption and a silent gap at every handover.
module sound_arbiter import nap_pkg::*; #(
  parameter logic [BEAT_W-1:0] CLICK_TONE  = 13'd523,
  parameter int                CLICK_TICKS = 5,
  parameter int                GAP_TICKS   = 1
) (
  input logic            clock,
  input logic            reset,
  sound_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(max_int(CLICK_TICKS, GAP_TICKS) + 1);

  state_e            state_q, state_d, idle_next;
  logic              click_pend_q, click_pend_d;
  logic [BEAT_W-1:0] play_q, play_d;
  logic [2:0]        grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              timer_clr, timer_done;
  logic [CNT_W-1:0]  timer_limit;

  assign timer_limit = (state_q == ST_CLICK) ? CNT_W'(CLICK_TICKS) : CNT_W'(GAP_TICKS);

  tick_timer #(.CNT_W(CNT_W)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (timer_clr),
    .tick_i  (bus.tick),
    .limit_i (timer_limit),
    .done_o  (timer_done)
  );

  always_comb begin
    state_d      = state_q;
    click_pend_d = click_pend_q;
    timer_clr    = 1'b0;
    play_d       = '0;
    grant_d      = '0;
    idle_next    = ST_IDLE;

    if (bus.req_alarm) begin
      idle_next = ST_ALARM;
    end else if (click_pend_q) begin
      idle_next = ST_CLICK;
    end else if (bus.req_lullaby) begin
      idle_next = ST_LULLABY;
    end

    case (state_q)
      ST_IDLE: state_d = idle_next;
      ST_LULLABY: begin
        if (bus.req_alarm || click_pend_q) begin
          state_d = ST_GAP;
        end else if (!bus.req_lullaby) begin
          state_d = ST_IDLE;
        end
      end
      ST_ALARM: if (!bus.req_alarm) state_d = ST_IDLE;
      ST_CLICK: begin
        // an alarm aborts the click outright; a repeated key only stretches it
        if (bus.req_alarm) begin
          state_d = ST_GAP;
        end else if (bus.key_press) begin
          timer_clr = 1'b1;
        end else if (timer_done) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: if (timer_done) state_d = idle_next;
      default: state_d = ST_IDLE;
    endcase

    if ((state_d != state_q) && ((state_d == ST_CLICK) || (state_d == ST_GAP))) begin
      timer_clr = 1'b1;
    end

    if ((state_d == ST_CLICK) && (state_q != ST_CLICK)) begin
      click_pend_d = 1'b0;
    end else if (bus.key_press && !bus.req_alarm &&
                 (state_q != ST_ALARM) && (state_q != ST_CLICK)) begin
      click_pend_d = 1'b1;
    end

    case (state_d)
      ST_LULLABY: begin
        play_d               = bus.beat_lullaby;
        grant_d[GNT_LULLABY] = 1'b1;
      end
      ST_CLICK: begin
        play_d             = CLICK_TONE;
        grant_d[GNT_CLICK] = 1'b1;
      end
      ST_ALARM: begin
        play_d             = bus.beat_alarm;
        grant_d[GNT_ALARM] = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      click_pend_q <= 1'b0;
      play_q       <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      click_pend_q <= click_pend_d;
      play_q       <= play_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.playSound = play_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sound_arbiter.sv
// tb/tb_sound_arbiter.sv - directed scoreboard bench for sound_arbiter
module tb_sound_arbiter;
  import nap_pkg::*;

  typedef struct packed {
    logic [BEAT_W-1:0] play;
    logic [2:0]        gnt;
    logic              busy;
  } exp_t;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;
  int   step_n;
  exp_t sb_q[$];

  sound_arbiter_if bus ();

  sound_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic compare_top();
    exp_t e;
    e = sb_q.pop_front();
    chk($sformatf("playSound@%0d", step_n), 16'(bus.playSound), 16'(e.play));
    chk($sformatf("grant@%0d", step_n), 16'(bus.grant), 16'(e.gnt));
    chk($sformatf("busy@%0d", step_n), 16'(bus.busy), 16'(e.busy));
  endtask

  task automatic step(input logic t, input logic k, input logic [BEAT_W-1:0] ep,
                      input logic [2:0] eg, input logic eb);
    bus.tick      = t;
    bus.key_press = k;
    sb_q.push_back('{ep, eg, eb});
    @(posedge clock);
    #1;
    bus.tick      = 1'b0;
    bus.key_press = 1'b0;
    step_n++;
    compare_top();
  endtask

  task automatic check_now(input logic [BEAT_W-1:0] ep, input logic [2:0] eg, input logic eb);
    sb_q.push_back('{ep, eg, eb});
    step_n++;
    compare_top();
  endtask

  task automatic async_reset_check();
    reset = 1'b1;
    #1;
    check_now('0, 3'b000, 1'b0);
    @(posedge clock);
    #1;
    check_now('0, 3'b000, 1'b0);
    bus.req_lullaby = 1'b0;
    bus.req_alarm   = 1'b0;
    reset           = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    step_n = 0;
    reset = 1'b1;
    bus.tick = 1'b0;
    bus.key_press = 1'b0;
    bus.req_alarm = 1'b0;
    bus.req_lullaby = 1'b0;
    bus.beat_alarm = '0;
    bus.beat_lullaby = '0;

    @(posedge clock);
    #1;
    check_now('0, 3'b000, 1'b0);
    reset = 1'b0;
    step(0, 0, 0, 3'b000, 0);

    // lullaby grant and beat tracking
    bus.req_lullaby = 1'b1;
    bus.beat_lullaby = 13'd100;
    step(0, 0, 100, 3'b001, 1);
    bus.beat_lullaby = 13'd200;
    step(0, 0, 200, 3'b001, 1);
    bus.beat_lullaby = 13'd300;
    step(0, 0, 300, 3'b001, 1);

    // click preempts lullaby, tick every other cycle
    step(0, 1, 300, 3'b001, 1);
    step(1, 0, 0, 3'b000, 1);
    step(0, 0, 0, 3'b000, 1);
    step(1, 0, 523, 3'b010, 1);
    for (int i = 4; i <= 12; i++) step(logic'(i % 2), 0, 523, 3'b010, 1);
    step(1, 0, 0, 3'b000, 1);
    step(0, 0, 0, 3'b000, 1);
    bus.beat_lullaby = 13'd400;
    step(1, 0, 400, 3'b001, 1);

    // alarm aborts a click at tick 2; key during alarm discarded
    bus.req_lullaby = 1'b0;
    step(0, 0, 0, 3'b000, 0);
    step(0, 1, 0, 3'b000, 0);
    step(0, 0, 523, 3'b010, 1);
    step(1, 0, 523, 3'b010, 1);
    step(1, 0, 523, 3'b010, 1);
    bus.req_alarm = 1'b1;
    bus.beat_alarm = 13'd700;
    step(0, 0, 0, 3'b000, 1);
    step(1, 0, 700, 3'b100, 1);
    step(0, 1, 700, 3'b100, 1);
    bus.beat_alarm = 13'd750;
    step(0, 0, 750, 3'b100, 1);
    bus.req_alarm = 1'b0;
    step(0, 0, 0, 3'b000, 0);
    step(0, 0, 0, 3'b000, 0);
    step(0, 0, 0, 3'b000, 0);

    // key and alarm together from idle
    bus.req_alarm = 1'b1;
    bus.beat_alarm = 13'd800;
    step(0, 1, 800, 3'b100, 1);
    bus.req_alarm = 1'b0;
    step(0, 0, 0, 3'b000, 0);
    step(0, 0, 0, 3'b000, 0);

    // async reset mid-gap
    bus.req_lullaby = 1'b1;
    bus.beat_lullaby = 13'd100;
    step(0, 0, 100, 3'b001, 1);
    step(0, 1, 100, 3'b001, 1);
    step(0, 0, 0, 3'b000, 1);
    async_reset_check();
    step(0, 0, 0, 3'b000, 0);
    step(1, 0, 0, 3'b000, 0);

    // async reset mid-click
    step(0, 1, 0, 3'b000, 0);
    step(0, 0, 523, 3'b010, 1);
    step(1, 0, 523, 3'b010, 1);
    async_reset_check();
    step(0, 0, 0, 3'b000, 0);
    step(1, 0, 0, 3'b000, 0);

    // fresh click with a tick every cycle runs exactly CLICK_TICKS
    step(0, 1, 0, 3'b000, 0);
    step(0, 0, 523, 3'b010, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 523, 3'b010, 1);
    step(1, 0, 0, 3'b000, 1);
    step(1, 0, 0, 3'b000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
